// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the video RAM write-port arbiter.
//   DATA_WIDTH   colour bits per pixel
//   ADDR_WIDTH   video RAM address width
//   MEM_WIDTH    pixels per row
//   MEM_HEIGHT   rows
//   COORD_WIDTH  width of the fill rectangle coordinate inputs
//   fill_state_e fill engine FSM encoding
// ---------------------------------------------------------------------------
package vga_pkg;
    localparam int DATA_WIDTH  = 3;
    localparam int ADDR_WIDTH  = 11;
    localparam int MEM_WIDTH   = 40;
    localparam int MEM_HEIGHT  = 30;
    localparam int COORD_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLIP = 2'd1,
        ST_FILL = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;
endpackage

// File: rtl/vga_rect_clip.sv
// ---------------------------------------------------------------------------
// vga_rect_clip
// Combinational normalisation of a fill rectangle: orders each coordinate
// pair so the low bound comes first, then clamps every bound onto the
// visible screen (columns 0..MEM_WIDTH-1, rows 0..MEM_HEIGHT-1).
// Ports:
//   x0_i, x1_i, y0_i, y1_i  raw inclusive bounds, any order
//   x0_o, x1_o, y0_o, y1_o  ordered (x0_o <= x1_o, y0_o <= y1_o), clamped
// ---------------------------------------------------------------------------
module vga_rect_clip
    import vga_pkg::*;
(
    input  logic [COORD_WIDTH-1:0] x0_i,
    input  logic [COORD_WIDTH-1:0] x1_i,
    input  logic [COORD_WIDTH-1:0] y0_i,
    input  logic [COORD_WIDTH-1:0] y1_i,
    output logic [COORD_WIDTH-1:0] x0_o,
    output logic [COORD_WIDTH-1:0] x1_o,
    output logic [COORD_WIDTH-1:0] y0_o,
    output logic [COORD_WIDTH-1:0] y1_o
);
    localparam logic [COORD_WIDTH-1:0] X_MAX = COORD_WIDTH'(MEM_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_MAX = COORD_WIDTH'(MEM_HEIGHT - 1);

    logic [COORD_WIDTH-1:0] lo_x, hi_x, lo_y, hi_y;

    always_comb begin
        lo_x = (x0_i > x1_i) ? x1_i : x0_i;
        hi_x = (x0_i > x1_i) ? x0_i : x1_i;
        lo_y = (y0_i > y1_i) ? y1_i : y0_i;
        hi_y = (y0_i > y1_i) ? y0_i : y1_i;
        // Clamping after ordering keeps lo <= hi, so the fill loop always
        // terminates inside the screen and never wraps an address.
        x0_o = (lo_x > X_MAX) ? X_MAX : lo_x;
        x1_o = (hi_x > X_MAX) ? X_MAX : hi_x;
        y0_o = (lo_y > Y_MAX) ? Y_MAX : lo_y;
        y1_o = (hi_y > Y_MAX) ? Y_MAX : hi_y;
    end
endmodule

// File: rtl/vga_fill_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fill_arbiter
// Owns the single write port of the 40x30 video RAM and shares it between
// CPU pixel writes and a rectangle-fill engine (clear screen / box fill).
// Ports:
//   Clock, Reset            system clock, synchronous active-high reset
//   iCpuWrite/Addr/Data     CPU write request (single cycle, never stalled)
//   iFillStart              start pulse, accepted only while idle
//   iFillColor              fill colour
//   iFillX0/X1, iFillY0/Y1  inclusive rectangle bounds, any order
//   oFillBusy               fill engine not idle
//   oFillDone               one-cycle pulse with the last fill write
//   oMemWrite/Addr/Data     registered write port to the video RAM
//   oDbgState               current fill FSM state
// Handshake: iCpuWrite is a valid-only request with no ready; the CPU owns
// the port in any cycle it asserts iCpuWrite and the fill engine simply
// holds its position and retries the same pixel on the next free cycle.
// ---------------------------------------------------------------------------
module vga_fill_arbiter
    import vga_pkg::*;
(
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   iCpuWrite,
    input  logic [ADDR_WIDTH-1:0]  iCpuAddr,
    input  logic [DATA_WIDTH-1:0]  iCpuData,
    input  logic                   iFillStart,
    input  logic [DATA_WIDTH-1:0]  iFillColor,
    input  logic [COORD_WIDTH-1:0] iFillX0,
    input  logic [COORD_WIDTH-1:0] iFillX1,
    input  logic [COORD_WIDTH-1:0] iFillY0,
    input  logic [COORD_WIDTH-1:0] iFillY1,
    output logic                   oFillBusy,
    output logic                   oFillDone,
    output logic                   oMemWrite,
    output logic [ADDR_WIDTH-1:0]  oMemAddr,
    output logic [DATA_WIDTH-1:0]  oMemData,
    output fill_state_e            oDbgState
);
    fill_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]  color_q, color_d;
    logic [COORD_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [COORD_WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_WIDTH-1:0]  rowbase_q, rowbase_d;
    logic                   mem_write_q, mem_write_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [COORD_WIDTH-1:0] clip_x0, clip_x1, clip_y0, clip_y1;

    // The latched raw bounds are normalised during CLIP and written back
    // over themselves, so x0_q..y1_q hold clipped bounds from FILL onward.
    vga_rect_clip u_clip (
        .x0_i (x0_q),
        .x1_i (x1_q),
        .y0_i (y0_q),
        .y1_i (y1_q),
        .x0_o (clip_x0),
        .x1_o (clip_x1),
        .y0_o (clip_y0),
        .y1_o (clip_y1)
    );

    always_comb begin
        state_d     = state_q;
        color_d     = color_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        x_d         = x_q;
        y_d         = y_q;
        rowbase_d   = rowbase_q;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (iFillStart) begin
                    color_d = iFillColor;
                    x0_d    = iFillX0;
                    x1_d    = iFillX1;
                    y0_d    = iFillY0;
                    y1_d    = iFillY1;
                    state_d = ST_CLIP;
                end
            end
            ST_CLIP: begin
                x0_d      = clip_x0;
                x1_d      = clip_x1;
                y0_d      = clip_y0;
                y1_d      = clip_y1;
                x_d       = clip_x0;
                y_d       = clip_y0;
                rowbase_d = ADDR_WIDTH'(clip_y0) * ADDR_WIDTH'(MEM_WIDTH);
                state_d   = ST_FILL;
            end
            ST_FILL: begin
                // A CPU write this cycle freezes x/y/rowbase, so the same
                // pixel is issued on the next free cycle.
                if (!iCpuWrite) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = rowbase_q + ADDR_WIDTH'(x_q);
                    mem_data_d  = color_q;
                    if (x_q != x1_q) begin
                        x_d = x_q + COORD_WIDTH'(1);
                    end else if (y_q != y1_q) begin
                        x_d       = x0_q;
                        y_d       = y_q + COORD_WIDTH'(1);
                        rowbase_d = rowbase_q + ADDR_WIDTH'(MEM_WIDTH);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The CPU always owns the port when it asks, in every state.
        if (iCpuWrite) begin
            mem_write_d = 1'b1;
            mem_addr_d  = iCpuAddr;
            mem_data_d  = iCpuData;
        end

        // Status flags are registered from the next state so they line up
        // with state_q and with the registered write port.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            color_q     <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rowbase_q   <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rowbase_q   <= rowbase_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign oFillBusy = busy_q;
    assign oFillDone = done_q;
    assign oMemWrite = mem_write_q;
    assign oMemAddr  = mem_addr_q;
    assign oMemData  = mem_data_q;
    assign oDbgState = state_q;
endmodule

// File: tb/tb_vga_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fill_arbiter
// Self-checking bench for vga_fill_arbiter. Expected writes are pushed to
// exp_q as each scenario is set up; a monitor collects observed writes and
// each scenario task compares the two queues, timings and status flags.
// ---------------------------------------------------------------------------
module tb_vga_fill_arbiter;
    import vga_pkg::*;

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic                   Clock = 1'b0;
    logic                   Reset = 1'b1;
    logic                   iCpuWrite = 1'b0;
    logic [ADDR_WIDTH-1:0]  iCpuAddr = '0;
    logic [DATA_WIDTH-1:0]  iCpuData = '0;
    logic                   iFillStart = 1'b0;
    logic [DATA_WIDTH-1:0]  iFillColor = '0;
    logic [COORD_WIDTH-1:0] iFillX0 = '0, iFillX1 = '0, iFillY0 = '0, iFillY1 = '0;
    logic                   oFillBusy, oFillDone, oMemWrite;
    logic [ADDR_WIDTH-1:0]  oMemAddr;
    logic [DATA_WIDTH-1:0]  oMemData;
    fill_state_e            oDbgState;

    vga_fill_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWrite(iCpuWrite), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
        .iFillStart(iFillStart), .iFillColor(iFillColor),
        .iFillX0(iFillX0), .iFillX1(iFillX1), .iFillY0(iFillY0), .iFillY1(iFillY1),
        .oFillBusy(oFillBusy), .oFillDone(oFillDone),
        .oMemWrite(oMemWrite), .oMemAddr(oMemAddr), .oMemData(oMemData),
        .oDbgState(oDbgState)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 Clock = ~Clock;
    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        int                    cyc;
        logic                  done;
    } obs_t;

    obs_t            obs_q[$];
    logic [EW-1:0]   exp_q[$];
    int              done_cnt = 0;
    int              done_cyc = -1;
    int              checks = 0;
    int              failures = 0;

    always @(negedge Clock) begin
        obs_t o;
        if (oMemWrite === 1'b1) begin
            o.addr = oMemAddr;
            o.data = oMemData;
            o.cyc  = cyc;
            o.done = oFillDone;
            obs_q.push_back(o);
        end
        if (oFillDone === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic start_fill(input logic [DATA_WIDTH-1:0] c,
                              input logic [COORD_WIDTH-1:0] x0, input logic [COORD_WIDTH-1:0] x1,
                              input logic [COORD_WIDTH-1:0] y0, input logic [COORD_WIDTH-1:0] y1,
                              output int scyc);
        iFillStart = 1'b1;
        iFillColor = c;
        iFillX0 = x0; iFillX1 = x1; iFillY0 = y0; iFillY1 = y1;
        scyc = cyc;
        @(negedge Clock);
        iFillStart = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (oFillDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge Clock);
        checks++;
        if ({oMemWrite, oMemAddr, oMemData, oFillBusy, oFillDone} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {oMemWrite, oMemAddr, oMemData, oFillBusy, oFillDone});
        end
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (oDbgState !== ST_IDLE || oFillBusy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%0d busy=%b exp=0 busy=0", oDbgState, oFillBusy);
        end
    endtask

    task automatic test_full_clear();
        int s; bit seen;
        clear_sb();
        for (int a = 0; a < 1200; a++) exp_q.push_back({ADDR_WIDTH'(a), 3'b000});
        start_fill(3'b000, 6'd0, 6'd39, 6'd0, 6'd29, s);
        wait_done(1300, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL clear_done_timeout got=none exp=pulse"); end
        @(negedge Clock);
        checks++;
        if (oFillBusy !== 1'b0) begin failures++; $display("FAIL clear_busy_after got=%b exp=0", oFillBusy); end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL clear_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                failures++;
                $display("FAIL clear_seq idx=%0d got=%h exp=%h", i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
                break;
            end
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[0].cyc != s + 3) begin
            failures++; $display("FAIL clear_first_latency got=%0d exp=%0d", obs_q.size() ? obs_q[0].cyc - s : -1, 3);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != s + 1202) begin
            failures++; $display("FAIL clear_done_pulse got=cnt%0d@%0d exp=cnt1@%0d", done_cnt, done_cyc - s, 1202);
        end
        checks++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1].done !== 1'b1 || obs_q[obs_q.size()-1].addr !== 11'd1199) begin
            failures++; $display("FAIL clear_done_with_last got=done not on addr 1199 exp=done on 1199");
        end
    endtask

    task automatic test_single_pixel();
        int s; bit seen;
        clear_sb();
        exp_q.push_back({11'd85, 3'b101});
        start_fill(3'b101, 6'd5, 6'd5, 6'd2, 6'd2, s);
        wait_done(20, seen);
        @(negedge Clock);
        checks++;
        if (!seen || obs_q.size() != 1) begin
            failures++; $display("FAIL single_count got=%0d seen=%b exp=1 seen=1", obs_q.size(), seen);
        end else begin
            checks++;
            if ({obs_q[0].addr, obs_q[0].data} !== exp_q[0]) begin
                failures++; $display("FAIL single_write got=%h exp=%h", {obs_q[0].addr, obs_q[0].data}, exp_q[0]);
            end
            checks++;
            if (obs_q[0].cyc != s + 3 || done_cyc != s + 3) begin
                failures++; $display("FAIL single_latency got=%0d/%0d exp=3/3", obs_q[0].cyc - s, done_cyc - s);
            end
        end
    endtask

    task automatic test_swap_clip();
        int s; bit seen;
        clear_sb();
        exp_q.push_back({11'd1, 3'd1}); exp_q.push_back({11'd2, 3'd1}); exp_q.push_back({11'd3, 3'd1});
        exp_q.push_back({11'd1198, 3'd6}); exp_q.push_back({11'd1199, 3'd6});
        start_fill(3'd1, 6'd3, 6'd1, 6'd0, 6'd0, s);
        wait_done(20, seen);
        @(negedge Clock);
        start_fill(3'd6, 6'd38, 6'd63, 6'd29, 6'd40, s);
        wait_done(20, seen);
        @(negedge Clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL clip_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                failures++;
                $display("FAIL clip_seq idx=%0d got=%h exp=%h", i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
            end
        end
    endtask

    task automatic test_cpu_preempt();
        int s; bit seen;
        clear_sb();
        for (int a = 0; a < 9; a++) exp_q.push_back({ADDR_WIDTH'(a), 3'b000});
        exp_q.push_back({11'd7, 3'd6});
        for (int a = 9; a < 1200; a++) exp_q.push_back({ADDR_WIDTH'(a), 3'b000});
        start_fill(3'b000, 6'd0, 6'd39, 6'd0, 6'd29, s);
        repeat (10) @(negedge Clock);
        iCpuWrite = 1'b1; iCpuAddr = 11'd7; iCpuData = 3'd6;
        @(negedge Clock);
        iCpuWrite = 1'b0;
        wait_done(1300, seen);
        @(negedge Clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL preempt_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                failures++;
                $display("FAIL preempt_seq idx=%0d got=%h exp=%h", i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
                break;
            end
        end
        checks++;
        if (obs_q.size() < 10 || obs_q[9].cyc != s + 12) begin
            failures++; $display("FAIL preempt_cpu_latency got=%0d exp=%0d", obs_q.size() >= 10 ? obs_q[9].cyc - s : -1, 12);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != s + 1203) begin
            failures++; $display("FAIL preempt_done got=cnt%0d@%0d exp=cnt1@%0d", done_cnt, done_cyc - s, 1203);
        end
    endtask

    task automatic test_restart_ignored();
        int s, s2; bit seen;
        clear_sb();
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 4; x++) exp_q.push_back({ADDR_WIDTH'(y * 40 + x), 3'd2});
        start_fill(3'd2, 6'd0, 6'd3, 6'd0, 6'd1, s);
        repeat (3) @(negedge Clock);
        start_fill(3'd7, 6'd10, 6'd12, 6'd10, 6'd12, s2);
        wait_done(40, seen);
        repeat (12) @(negedge Clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL restart_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                failures++;
                $display("FAIL restart_seq idx=%0d got=%h exp=%h", i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != s + 10) begin
            failures++; $display("FAIL restart_done got=cnt%0d@%0d exp=cnt1@10", done_cnt, done_cyc - s);
        end
    endtask

    task automatic test_reset_mid_fill();
        int s, n_before; bit seen;
        clear_sb();
        start_fill(3'd4, 6'd0, 6'd39, 6'd0, 6'd29, s);
        repeat (20) @(negedge Clock);
        checks++;
        if (oFillBusy !== 1'b1 || oDbgState !== ST_FILL) begin
            failures++; $display("FAIL midfill_busy got=%b/%0d exp=1/%0d", oFillBusy, oDbgState, ST_FILL);
        end
        Reset = 1'b1;
        @(negedge Clock);
        checks++;
        if ({oMemWrite, oMemAddr, oMemData, oFillBusy, oFillDone} !== '0 || oDbgState !== ST_IDLE) begin
            failures++;
            $display("FAIL midfill_reset_outputs got=%h st=%0d exp=0 st=0",
                     {oMemWrite, oMemAddr, oMemData, oFillBusy, oFillDone}, oDbgState);
        end
        Reset = 1'b0;
        n_before = obs_q.size();
        repeat (30) @(negedge Clock);
        checks++;
        if (obs_q.size() != n_before || done_cnt != 0) begin
            failures++; $display("FAIL midfill_after_reset got=writes%0d done%0d exp=writes0 done0",
                                 obs_q.size() - n_before, done_cnt);
        end
        clear_sb();
        exp_q.push_back({11'd1199, 3'd7});
        start_fill(3'd7, 6'd39, 6'd39, 6'd29, 6'd29, s);
        wait_done(20, seen);
        @(negedge Clock);
        checks++;
        if (obs_q.size() != 1 || {obs_q[0].addr, obs_q[0].data} !== exp_q[0] || obs_q[0].cyc != s + 3) begin
            failures++; $display("FAIL restart_after_reset got=n%0d exp=n1 addr 1199 data 7 at +3", obs_q.size());
        end
    endtask

    task automatic test_cpu_with_start();
        int s; bit seen;
        clear_sb();
        exp_q.push_back({11'd100, 3'd3});
        exp_q.push_back({11'd0, 3'd4});
        exp_q.push_back({11'd1, 3'd4});
        iCpuWrite = 1'b1; iCpuAddr = 11'd100; iCpuData = 3'd3;
        start_fill(3'd4, 6'd0, 6'd1, 6'd0, 6'd0, s);
        iCpuWrite = 1'b0;
        wait_done(20, seen);
        @(negedge Clock);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL cpu_start_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                failures++;
                $display("FAIL cpu_start_seq idx=%0d got=%h exp=%h", i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
            end
        end
        checks++;
        if (obs_q.size() < 2 || obs_q[0].cyc != s + 1 || obs_q[1].cyc != s + 3) begin
            failures++; $display("FAIL cpu_start_timing got=n%0d exp=cpu@+1 fill@+3", obs_q.size());
        end
    endtask

    task automatic test_random_rects();
        int s, lx, hx, ly, hy; bit seen;
        logic [COORD_WIDTH-1:0] ax, bx, ay, by;
        logic [DATA_WIDTH-1:0] c;
        for (int it = 0; it < 4; it++) begin
            clear_sb();
            ax = COORD_WIDTH'($urandom_range(0, 63)); bx = COORD_WIDTH'($urandom_range(0, 63));
            ay = COORD_WIDTH'($urandom_range(0, 63)); by = COORD_WIDTH'($urandom_range(0, 63));
            c  = DATA_WIDTH'($urandom_range(0, 7));
            lx = (ax < bx) ? int'(ax) : int'(bx); hx = (ax < bx) ? int'(bx) : int'(ax);
            ly = (ay < by) ? int'(ay) : int'(by); hy = (ay < by) ? int'(by) : int'(ay);
            if (lx > 39) lx = 39;
            if (hx > 39) hx = 39;
            if (ly > 29) ly = 29;
            if (hy > 29) hy = 29;
            for (int y = ly; y <= hy; y++)
                for (int x = lx; x <= hx; x++) exp_q.push_back({ADDR_WIDTH'(y * 40 + x), c});
            start_fill(c, ax, bx, ay, by, s);
            wait_done(1300, seen);
            @(negedge Clock);
            checks++;
            if (obs_q.size() != exp_q.size() || done_cyc != s + 2 + exp_q.size()) begin
                failures++; $display("FAIL rand%0d_count got=%0d@%0d exp=%0d@%0d", it, obs_q.size(),
                                     done_cyc - s, exp_q.size(), 2 + exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if ({obs_q[i].addr, obs_q[i].data} !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d_seq idx=%0d got=%h exp=%h", it, i, {obs_q[i].addr, obs_q[i].data}, exp_q[i]);
                    break;
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_full_clear();
        test_single_pixel();
        test_swap_clip();
        test_cpu_preempt();
        test_restart_ignored();
        test_reset_mid_fill();
        test_cpu_with_start();
        test_random_rects();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
